// File: rtl/mem_arbiter.sv
// Two-port (CPU read/write, VIC read-only) arbiter in front of a single memory controller.
// Round-robin between requesters; one transaction in flight, aborted with err after TIMEOUT wait cycles.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [5:0]  cpu_bank,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_err,
  input  logic        vic_req,
  input  logic [5:0]  vic_bank,
  input  logic [15:0] vic_addr,
  output logic        vic_ack,
  output logic [7:0]  vic_rdata,
  output logic        vic_err,
  output logic        mem_CE,
  output logic        mem_write,
  output logic [5:0]  mem_bank,
  output logic [15:0] mem_addrBus,
  output logic [7:0]  mem_dataToWrite,
  input  logic [7:0]  mem_dataRead,
  input  logic        mem_isBusy,
  input  logic        mem_dataReady,
  output logic        grant_vic
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_vic;
  logic        r_gnt_vic;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_inc;
  logic        w_grant;
  logic        w_pick_vic;
  logic        w_timeout;
  logic        r_mem_write;
  logic [5:0]  r_mem_bank;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic [7:0]  r_cpu_rdata;
  logic        r_cpu_err;
  logic [7:0]  r_vic_rdata;
  logic        r_vic_err;

  // VIC wins a tie unless it was the one served last.
  always_comb begin
    w_pick_vic  = vic_req & (~cpu_req | ~r_last_vic);
    w_grant     = ~mem_isBusy & (cpu_req | vic_req);
    w_cnt_inc   = r_cnt + 8'd1;
    w_timeout   = (w_cnt_inc == TIMEOUT_CNT);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (mem_dataReady || w_timeout) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_vic  <= 1'b0;
      r_gnt_vic   <= 1'b0;
      r_cnt       <= 8'd0;
      r_mem_write <= 1'b0;
      r_mem_bank  <= 6'd0;
      r_mem_addr  <= 16'd0;
      r_mem_wdata <= 8'd0;
      r_cpu_rdata <= 8'd0;
      r_cpu_err   <= 1'b0;
      r_vic_rdata <= 8'd0;
      r_vic_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_gnt_vic   <= w_pick_vic;
            r_mem_bank  <= w_pick_vic ? vic_bank : cpu_bank;
            r_mem_addr  <= w_pick_vic ? vic_addr : cpu_addr;
            r_mem_write <= ~w_pick_vic & cpu_write;
            r_mem_wdata <= w_pick_vic ? 8'd0 : cpu_wdata;
          end
        end
        S_ISSUE: r_cnt <= 8'd0;
        S_WAIT: begin
          r_cnt <= w_cnt_inc;
          // Data arriving on the timeout cycle still counts as success.
          if (mem_dataReady) begin
            if (r_gnt_vic) begin
              r_vic_rdata <= mem_dataRead;
              r_vic_err   <= 1'b0;
            end else begin
              if (!r_mem_write) r_cpu_rdata <= mem_dataRead;
              r_cpu_err <= 1'b0;
            end
          end else if (w_timeout) begin
            if (r_gnt_vic) begin
              r_vic_rdata <= 8'hFF;
              r_vic_err   <= 1'b1;
            end else begin
              if (!r_mem_write) r_cpu_rdata <= 8'hFF;
              r_cpu_err <= 1'b1;
            end
          end
        end
        S_DONE: r_last_vic <= r_gnt_vic;
        default: ;
      endcase
    end
  end

  assign mem_CE          = (r_state == S_ISSUE);
  assign cpu_ack         = (r_state == S_DONE) & ~r_gnt_vic;
  assign vic_ack         = (r_state == S_DONE) & r_gnt_vic;
  assign mem_write       = r_mem_write;
  assign mem_bank        = r_mem_bank;
  assign mem_addrBus     = r_mem_addr;
  assign mem_dataToWrite = r_mem_wdata;
  assign cpu_rdata       = r_cpu_rdata;
  assign cpu_err         = r_cpu_err;
  assign vic_rdata       = r_vic_rdata;
  assign vic_err         = r_vic_err;
  assign grant_vic       = r_gnt_vic;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle, plus directed literal checks.
module tb_mem_arbiter;
  localparam int TIMEOUT = 255;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_write;
  logic [5:0]  cpu_bank;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack, cpu_err;
  logic [7:0]  cpu_rdata;
  logic        vic_req;
  logic [5:0]  vic_bank;
  logic [15:0] vic_addr;
  logic        vic_ack, vic_err;
  logic [7:0]  vic_rdata;
  logic        mem_CE, mem_write;
  logic [5:0]  mem_bank;
  logic [15:0] mem_addrBus;
  logic [7:0]  mem_dataToWrite;
  logic [7:0]  mem_dataRead;
  logic        mem_isBusy, mem_dataReady;
  logic        grant_vic;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_bank(cpu_bank), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .vic_req(vic_req), .vic_bank(vic_bank), .vic_addr(vic_addr),
    .vic_ack(vic_ack), .vic_rdata(vic_rdata), .vic_err(vic_err),
    .mem_CE(mem_CE), .mem_write(mem_write), .mem_bank(mem_bank), .mem_addrBus(mem_addrBus),
    .mem_dataToWrite(mem_dataToWrite), .mem_dataRead(mem_dataRead), .mem_isBusy(mem_isBusy),
    .mem_dataReady(mem_dataReady), .grant_vic(grant_vic)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Transaction model: one outstanding transfer, described by its phase and elapsed wait cycles.
  bit          m_busy, m_issue, m_ack, m_vic, m_last;
  int          m_waited;
  logic        m_write;
  logic [5:0]  m_bank;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_cpu_rdata, m_vic_rdata;
  logic        m_cpu_err, m_vic_err;

  // Memory responder: ready arrives rsp_delay wait cycles after CE (0 = never).
  int          rsp_delay;
  logic [7:0]  rsp_data;
  int          cd;
  bit          spur;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_issue = 0; m_ack = 0; m_vic = 0; m_last = 0; m_waited = 0;
    m_write = 0; m_bank = 0; m_addr = 0; m_wdata = 0;
    m_cpu_rdata = 0; m_cpu_err = 0; m_vic_rdata = 0; m_vic_err = 0;
  endtask

  task automatic model_finish(input logic [7:0] d, input logic e);
    if (m_vic) begin
      m_vic_rdata = d; m_vic_err = e;
    end else begin
      if (!m_write) m_cpu_rdata = d;
      m_cpu_err = e;
    end
    m_ack = 1;
  endtask

  task automatic model_step();
    bit pick;
    if (m_ack) begin
      m_ack = 0; m_busy = 0; m_last = m_vic;
    end else if (!m_busy) begin
      if (!mem_isBusy && (cpu_req || vic_req)) begin
        if (cpu_req && vic_req) pick = !m_last;
        else                    pick = vic_req;
        m_vic   = pick;
        m_bank  = pick ? vic_bank : cpu_bank;
        m_addr  = pick ? vic_addr : cpu_addr;
        m_write = pick ? 1'b0 : cpu_write;
        m_wdata = pick ? 8'd0 : cpu_wdata;
        m_busy  = 1; m_issue = 1;
      end
    end else if (m_issue) begin
      m_issue = 0; m_waited = 0;
    end else begin
      m_waited++;
      if (mem_dataReady)           model_finish(mem_dataRead, 1'b0);
      else if (m_waited == TIMEOUT) model_finish(8'hFF, 1'b1);
    end
  endtask

  function automatic logic [52:0] dut_vec();
    return {mem_CE, mem_write, mem_bank, mem_addrBus, mem_dataToWrite, cpu_ack, cpu_rdata,
            cpu_err, vic_ack, vic_rdata, vic_err, grant_vic};
  endfunction

  function automatic logic [52:0] exp_vec();
    return {m_issue, m_write, m_bank, m_addr, m_wdata, m_ack && !m_vic, m_cpu_rdata,
            m_cpu_err, m_ack && m_vic, m_vic_rdata, m_vic_err, m_vic};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    if (!reset) begin model_reset(); cd = 0; end
    mem_dataReady = spur;
    if (spur) mem_dataRead = 8'hEE;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin mem_dataReady = 1'b1; mem_dataRead = rsp_data; end
    end
    if (mem_CE && rsp_delay > 0) cd = rsp_delay;
    check("cycle", {11'd0, dut_vec()}, {11'd0, exp_vec()});
  endtask

  task automatic wait_ack(input bit vic, input int bound, output int n);
    n = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      n++;
      if ((vic ? vic_ack : cpu_ack) === 1'b1) return;
    end
    checks++;
    failures++;
    $display("FAIL ack_wait got=no ack after %0d cycles required=ack", n);
  endtask

  task automatic reset_now();
    #2 reset = 1'b0;
    #1;
    model_reset();
    cd = 0;
  endtask

  initial begin
    int n;
    logic [3:0] order;
    int nacks;
    reset = 0; cpu_req = 0; cpu_write = 0; cpu_bank = 0; cpu_addr = 0; cpu_wdata = 0;
    vic_req = 0; vic_bank = 0; vic_addr = 0; mem_dataRead = 0; mem_isBusy = 0;
    mem_dataReady = 0; rsp_delay = 1; rsp_data = 0; cd = 0; spur = 0;
    model_reset();
    repeat (3) tick();
    check("rst_addr", mem_addrBus, 16'h0);
    check("rst_gvic", grant_vic, 1'b0);
    check("rst_ack", {cpu_ack, vic_ack, cpu_err, vic_err}, 4'b0);
    reset = 1'b1;
    tick();

    // CPU read, minimum latency
    cpu_req = 1; cpu_bank = 0; cpu_addr = 16'hC000; cpu_write = 0; rsp_delay = 1; rsp_data = 8'h79;
    tick();
    check("rd_ce", mem_CE, 1'b1);
    check("rd_addr", mem_addrBus, 16'hC000);
    tick();
    check("rd_ce_off", mem_CE, 1'b0);
    tick();
    check("rd_ack", cpu_ack, 1'b1);
    check("rd_data", cpu_rdata, 8'h79);
    check("rd_err", cpu_err, 1'b0);
    cpu_req = 0;
    tick();
    check("rd_ack_1cyc", cpu_ack, 1'b0);

    // CPU write
    cpu_req = 1; cpu_write = 1; cpu_wdata = 8'd121;
    tick();
    check("wr_ce", mem_CE, 1'b1);
    check("wr_write", mem_write, 1'b1);
    check("wr_wdata", mem_dataToWrite, 8'd121);
    wait_ack(1'b0, 10, n);
    check("wr_lat", n, 2);
    check("wr_rdata_kept", cpu_rdata, 8'h79);
    cpu_req = 0; cpu_write = 0;
    tick();

    // Spurious ready while idle
    spur = 1;
    repeat (3) tick();
    spur = 0;
    tick();
    check("spur_rdata", cpu_rdata, 8'h79);

    // Requester drops req right after grant
    cpu_req = 1; cpu_bank = 6'd5; cpu_addr = 16'h1234; rsp_data = 8'h3C;
    tick();
    cpu_req = 0;
    wait_ack(1'b0, 10, n);
    check("drop_lat", n, 2);
    check("drop_data", cpu_rdata, 8'h3C);
    tick();

    // Memory busy holds off the grant
    mem_isBusy = 1; cpu_req = 1; cpu_addr = 16'h0042; rsp_data = 8'h11;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("busy_no_ce", mem_CE, 1'b0);
    end
    mem_isBusy = 0;
    tick();
    check("busy_ce_after", mem_CE, 1'b1);
    wait_ack(1'b0, 10, n);
    check("busy_data", cpu_rdata, 8'h11);
    cpu_req = 0;
    tick();

    // VIC timeout, then a normal VIC read
    rsp_delay = 0; vic_req = 1; vic_bank = 6'd3; vic_addr = 16'hABCD;
    tick();
    check("to_ce", mem_CE, 1'b1);
    check("to_vic_wr", mem_write, 1'b0);
    wait_ack(1'b1, 300, n);
    check("to_lat", n, 256);
    check("to_rdata", vic_rdata, 8'hFF);
    check("to_err", vic_err, 1'b1);
    vic_req = 0;
    tick();
    rsp_delay = 2; rsp_data = 8'h5A; vic_req = 1;
    wait_ack(1'b1, 10, n);
    check("vic2_lat", n, 4);
    check("vic2_data", vic_rdata, 8'h5A);
    check("vic2_err", vic_err, 1'b0);
    check("vic2_cpu_kept", cpu_rdata, 8'h11);
    vic_req = 0;
    tick();

    // Round-robin after reset
    reset_now();
    tick();
    reset = 1'b1;
    tick();
    rsp_delay = 1; rsp_data = 8'h22; cpu_req = 1; vic_req = 1; cpu_addr = 16'h0100; vic_addr = 16'h0200;
    order = 4'd0; nacks = 0;
    for (int i = 0; i < 60 && nacks < 4; i++) begin
      tick();
      check("one_ack", {cpu_ack & vic_ack}, 1'b0);
      if (cpu_ack || vic_ack) begin
        order = {order[2:0], vic_ack};
        nacks++;
      end
    end
    check("alt_count", nacks, 4);
    check("alt_order", order, 4'b1010);
    cpu_req = 0; vic_req = 0;
    tick();

    // Reset during WAIT
    rsp_delay = 0; cpu_req = 1; cpu_addr = 16'h7777;
    repeat (3) tick();
    check("mid_wait_addr", mem_addrBus, 16'h7777);
    reset_now();
    check("mid_rst_addr", mem_addrBus, 16'h0);
    check("mid_rst_rdata", cpu_rdata, 8'h0);
    check("mid_rst_ce_ack", {mem_CE, cpu_ack, vic_ack, grant_vic}, 4'b0);
    cpu_req = 0;
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_quiet", {mem_CE, cpu_ack, vic_ack}, 3'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
